// File: rtl/ysyx_22050710_bpu.sv
// Branch unit: direct-mapped BTB with saturating counters plus a registered branch resolver.
// Latency: lookup is combinational (0 cycles); resolve results appear 1 cycle after i_valid.
// Backpressure: none; accepts one resolve per cycle, back-to-back, and never stalls.
// Ports: i_fetch_pc -> o_pred_taken/o_pred_target (fetch-side lookup);
//        i_valid/i_brfunc/i_pc/i_imm/i_rs1data/i_rs2data/i_pred_* -> o_valid/o_dnpc/o_redirect;
//        o_br_cnt/o_mispred_cnt count resolved branches and mispredicts.
module ysyx_22050710_bpu #(
  parameter int XLEN        = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_BITS    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_valid,
  input  logic [3:0]      i_brfunc,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1data,
  input  logic [XLEN-1:0] i_rs2data,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_target,
  output logic            o_valid,
  output logic [XLEN-1:0] o_dnpc,
  output logic            o_redirect,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  // Weakly taken: MSB set, remaining bits clear.
  localparam logic [CNT_BITS-1:0] CNT_WT  = {1'b1, {(CNT_BITS-1){1'b0}}};

  localparam logic [3:0] BR_JAL  = 4'b0001;
  localparam logic [3:0] BR_JALR = 4'b0010;
  localparam logic [3:0] BR_BEQ  = 4'b0100;
  localparam logic [3:0] BR_BNE  = 4'b0101;
  localparam logic [3:0] BR_BLT  = 4'b0110;
  localparam logic [3:0] BR_BGE  = 4'b0111;
  localparam logic [3:0] BR_BLTU = 4'b1110;
  localparam logic [3:0] BR_BGEU = 4'b1111;

  // BTB storage; only the valid bits need reset.
  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
  logic [CNT_BITS-1:0]    btb_cnt_q [BTB_ENTRIES];

  // ---------------- Fetch-side lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = i_fetch_pc[IDX_W+1:2];
  assign f_tag = i_fetch_pc[XLEN-1:IDX_W+2];
  assign f_hit = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag);

  assign o_pred_taken  = f_hit && btb_cnt_q[f_idx][CNT_BITS-1];
  assign o_pred_target = o_pred_taken ? btb_tgt_q[f_idx] : i_fetch_pc + XLEN'(4);

  // ---------------- Resolve ----------------
  logic            is_jump, is_cond, is_op;
  logic            taken, mispred;
  logic [XLEN-1:0] jalr_sum, target, dnpc_d;

  always_comb begin
    is_jump = 1'b0;
    is_cond = 1'b0;
    taken   = 1'b0;
    unique case (i_brfunc)
      BR_JAL, BR_JALR: begin is_jump = 1'b1; taken = 1'b1; end
      BR_BEQ:  begin is_cond = 1'b1; taken = (i_rs1data == i_rs2data); end
      BR_BNE:  begin is_cond = 1'b1; taken = (i_rs1data != i_rs2data); end
      BR_BLT:  begin is_cond = 1'b1; taken = ($signed(i_rs1data) <  $signed(i_rs2data)); end
      BR_BGE:  begin is_cond = 1'b1; taken = ($signed(i_rs1data) >= $signed(i_rs2data)); end
      BR_BLTU: begin is_cond = 1'b1; taken = (i_rs1data <  i_rs2data); end
      BR_BGEU: begin is_cond = 1'b1; taken = (i_rs1data >= i_rs2data); end
      default: ;
    endcase
  end

  assign is_op    = is_jump || is_cond;
  assign jalr_sum = i_rs1data + i_imm;
  assign target   = (i_brfunc == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : i_pc + i_imm;
  assign dnpc_d   = taken ? target : i_pc + XLEN'(4);
  // A "none" op with a taken prediction also lands here and redirects to pc+4.
  assign mispred  = (taken != i_pred_taken) || (taken && (target != i_pred_target));

  // ---------------- BTB update ----------------
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic                r_hit, upd_en;
  logic [CNT_BITS-1:0] cnt_q_sel, cnt_d;

  assign r_idx     = i_pc[IDX_W+1:2];
  assign r_tag     = i_pc[XLEN-1:IDX_W+2];
  assign r_hit     = btb_vld_q[r_idx] && (btb_tag_q[r_idx] == r_tag);
  assign cnt_q_sel = btb_cnt_q[r_idx];
  // Misses allocate only when taken; hits always train.
  assign upd_en    = i_valid && is_op && (r_hit || taken);

  always_comb begin
    cnt_d = cnt_q_sel;
    if (!r_hit)       cnt_d = is_jump ? CNT_MAX : CNT_WT;
    else if (is_jump) cnt_d = CNT_MAX;
    else if (taken)   cnt_d = (cnt_q_sel == CNT_MAX) ? CNT_MAX : cnt_q_sel + 1'b1;
    else              cnt_d = (cnt_q_sel == '0) ? '0 : cnt_q_sel - 1'b1;
  end

  // ---------------- Registered state ----------------
  logic            vld_q, redir_q;
  logic [XLEN-1:0] dnpc_q;
  logic [31:0]     br_cnt_q, mis_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q     <= 1'b0;
      redir_q   <= 1'b0;
      dnpc_q    <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      btb_vld_q <= '0;
    end else begin
      vld_q   <= i_valid;
      redir_q <= i_valid && mispred;
      if (i_valid) begin
        dnpc_q <= dnpc_d;
        if (is_op)   br_cnt_q  <= br_cnt_q + 32'd1;
        if (mispred) mis_cnt_q <= mis_cnt_q + 32'd1;
      end
      if (upd_en) btb_vld_q[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (upd_en) begin
      btb_tag_q[r_idx] <= r_tag;
      btb_cnt_q[r_idx] <= cnt_d;
      if (taken) btb_tgt_q[r_idx] <= target;
    end
  end

  assign o_valid       = vld_q;
  assign o_dnpc        = dnpc_q;
  assign o_redirect    = redir_q;
  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_ysyx_22050710_bpu.sv
// Self-checking bench for ysyx_22050710_bpu with a reference BTB model and result scoreboard.
// Latency: expects resolve outputs one cycle after i_valid; lookups combinational.
// Backpressure: none exercised; the design always accepts.
module tb_ysyx_22050710_bpu;
  localparam int XLEN = 64;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [XLEN-1:0] i_fetch_pc;
  logic            o_pred_taken;
  logic [XLEN-1:0] o_pred_target;
  logic            i_valid;
  logic [3:0]      i_brfunc;
  logic [XLEN-1:0] i_pc, i_imm, i_rs1data, i_rs2data;
  logic            i_pred_taken;
  logic [XLEN-1:0] i_pred_target;
  logic            o_valid;
  logic [XLEN-1:0] o_dnpc;
  logic            o_redirect;
  logic [31:0]     o_br_cnt, o_mispred_cnt;

  always #5 i_clk = ~i_clk;

  ysyx_22050710_bpu #(.XLEN(64), .BTB_ENTRIES(16), .CNT_BITS(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_fetch_pc(i_fetch_pc), .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .i_valid(i_valid), .i_brfunc(i_brfunc), .i_pc(i_pc), .i_imm(i_imm),
    .i_rs1data(i_rs1data), .i_rs2data(i_rs2data),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_valid(o_valid), .o_dnpc(o_dnpc), .o_redirect(o_redirect),
    .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model of the BTB and counters.
  logic        m_vld [16];
  logic [57:0] m_tag [16];
  logic [63:0] m_tgt [16];
  logic [1:0]  m_cnt [16];
  logic [31:0] m_br, m_mis;

  typedef struct packed {
    logic [63:0] dnpc;
    logic        redir;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic m_ptaken(input logic [63:0] pc);
    return m_vld[pc[5:2]] && (m_tag[pc[5:2]] == pc[63:6]) && m_cnt[pc[5:2]][1];
  endfunction

  function automatic logic [63:0] m_ptgt(input logic [63:0] pc);
    return m_ptaken(pc) ? m_tgt[pc[5:2]] : pc + 64'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_vld[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = '0;
    end
    m_br = '0; m_mis = '0;
    exp_q.delete();
  endtask

  task automatic check_lookup(input logic [63:0] pc);
    i_fetch_pc = pc;
    #1;
    checks++;
    if (o_pred_taken !== m_ptaken(pc)) begin
      failures++;
      $display("FAIL lookup_taken pc=%h got=%b exp=%b", pc, o_pred_taken, m_ptaken(pc));
    end
    checks++;
    if (o_pred_target !== m_ptgt(pc)) begin
      failures++;
      $display("FAIL lookup_target pc=%h got=%h exp=%h", pc, o_pred_target, m_ptgt(pc));
    end
  endtask

  // Drives one resolve at the negedge; if use_model, the prediction comes from the model lookup.
  task automatic resolve(input logic [3:0] f, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input bit use_model, input logic ptk, input logic [63:0] ptg);
    logic tk, mp, jump, cond, hit;
    logic [63:0] tg, edn, ptg_u;
    logic ptk_u;
    int idx;
    exp_t e;
    @(negedge i_clk);
    ptk_u = use_model ? m_ptaken(pc) : ptk;
    ptg_u = use_model ? m_ptgt(pc) : ptg;
    i_valid = 1'b1; i_brfunc = f; i_pc = pc; i_imm = imm;
    i_rs1data = rs1; i_rs2data = rs2; i_pred_taken = ptk_u; i_pred_target = ptg_u;
    // Same-cycle lookup must see pre-update contents.
    check_lookup(pc);
    jump = (f == 4'b0001) || (f == 4'b0010);
    cond = (f inside {4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1110, 4'b1111});
    case (f)
      4'b0001, 4'b0010: tk = 1'b1;
      4'b0100: tk = (rs1 == rs2);
      4'b0101: tk = (rs1 != rs2);
      4'b0110: tk = ($signed(rs1) <  $signed(rs2));
      4'b0111: tk = ($signed(rs1) >= $signed(rs2));
      4'b1110: tk = (rs1 <  rs2);
      4'b1111: tk = (rs1 >= rs2);
      default: tk = 1'b0;
    endcase
    tg  = (f == 4'b0010) ? ((rs1 + imm) & ~64'd1) : pc + imm;
    edn = tk ? tg : pc + 64'd4;
    mp  = (tk != ptk_u) || (tk && (tg != ptg_u));
    exp_q.push_back('{dnpc: edn, redir: mp});
    if (jump || cond) m_br++;
    if (mp) m_mis++;
    idx = int'(pc[5:2]);
    hit = m_vld[idx] && (m_tag[idx] == pc[63:6]);
    if (jump || cond) begin
      if (hit) begin
        if (jump) m_cnt[idx] = 2'b11;
        else if (tk) m_cnt[idx] = (m_cnt[idx] == 2'b11) ? 2'b11 : m_cnt[idx] + 2'd1;
        else m_cnt[idx] = (m_cnt[idx] == 2'b00) ? 2'b00 : m_cnt[idx] - 2'd1;
        if (tk) m_tgt[idx] = tg;
      end else if (tk) begin
        m_vld[idx] = 1'b1; m_tag[idx] = pc[63:6]; m_tgt[idx] = tg;
        m_cnt[idx] = jump ? 2'b11 : 2'b10;
      end
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty pc=%h", pc);
    end else begin
      e = exp_q.pop_front();
      if (o_valid !== 1'b1 || o_dnpc !== e.dnpc || o_redirect !== e.redir) begin
        failures++;
        $display("FAIL resolve f=%b pc=%h got v=%b dnpc=%h redir=%b exp v=1 dnpc=%h redir=%b",
                 f, pc, o_valid, o_dnpc, o_redirect, e.dnpc, e.redir);
      end
    end
    checks++;
    if (o_br_cnt !== m_br || o_mispred_cnt !== m_mis) begin
      failures++;
      $display("FAIL counters got br=%0d mis=%0d exp br=%0d mis=%0d", o_br_cnt, o_mispred_cnt, m_br, m_mis);
    end
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL idle got v=%b redir=%b exp v=0 redir=0", o_valid, o_redirect);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_brfunc = '0; i_pc = '0; i_imm = '0;
    i_rs1data = '0; i_rs2data = '0; i_pred_taken = 1'b0; i_pred_target = '0;
    i_fetch_pc = 64'h8000_0000;
    model_reset();
    #12;
    checks++;
    if (o_valid !== 1'b0 || o_redirect !== 1'b0 || o_dnpc !== 64'd0 ||
        o_br_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b redir=%b dnpc=%h br=%0d mis=%0d exp all 0",
               o_valid, o_redirect, o_dnpc, o_br_cnt, o_mispred_cnt);
    end
    checks++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== 64'h8000_0004) begin
      failures++;
      $display("FAIL reset_lookup got tk=%b tgt=%h exp tk=0 tgt=80000004", o_pred_taken, o_pred_target);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_beq_mispredict();
    resolve(4'b0100, 64'h8000_0010, 64'h20, 64'd5, 64'd5, 1'b0, 1'b0, 64'd0);
    checks++;
    if (o_dnpc !== 64'h8000_0030 || o_redirect !== 1'b1 || o_mispred_cnt !== 32'd1) begin
      failures++;
      $display("FAIL beq_first got dnpc=%h redir=%b mis=%0d exp dnpc=80000030 redir=1 mis=1",
               o_dnpc, o_redirect, o_mispred_cnt);
    end
    idle();
    check_lookup(64'h8000_0010);
    checks++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== 64'h8000_0030) begin
      failures++;
      $display("FAIL beq_trained got tk=%b tgt=%h exp tk=1 tgt=80000030", o_pred_taken, o_pred_target);
    end
  endtask

  task automatic test_signed_unsigned();
    resolve(4'b0110, 64'h8000_0100, 64'h40, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 64'd0);
    resolve(4'b1110, 64'h8000_0180, 64'h40, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 64'd0);
    checks++;
    if (o_dnpc !== 64'h8000_0184) begin
      failures++;
      $display("FAIL bltu_not_taken got dnpc=%h exp dnpc=80000184", o_dnpc);
    end
    resolve(4'b0111, 64'h8000_0140, 64'h40, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 64'd0);
    resolve(4'b1111, 64'h8000_01c0, 64'h40, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 64'd0);
    idle();
  endtask

  task automatic test_jalr();
    resolve(4'b0010, 64'h8000_0200, 64'd0, 64'h8000_1003, 64'd0, 1'b1, 1'b0, 64'd0);
    checks++;
    if (o_dnpc !== 64'h8000_1002) begin
      failures++;
      $display("FAIL jalr_target got dnpc=%h exp dnpc=80001002", o_dnpc);
    end
    idle();
    resolve(4'b0010, 64'h8000_0200, 64'd0, 64'h8000_1003, 64'd0, 1'b1, 1'b0, 64'd0);
    checks++;
    if (o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL jalr_repeat got redir=%b exp redir=0", o_redirect);
    end
    idle();
  endtask

  task automatic test_saturation();
    // Back-to-back: 4 taken then 4 not-taken at one pc; each lookup sees the pre-update counter.
    for (int i = 0; i < 8; i++)
      resolve(4'b0100, 64'h8000_0400, 64'h10, 64'd7, (i < 4) ? 64'd7 : 64'd8, 1'b1, 1'b0, 64'd0);
    idle();
    check_lookup(64'h8000_0400);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  fn  [8] = '{4'b0101, 4'b1111, 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0001, 4'b0001};
    logic [63:0] pcs [8] = '{64'h8000_0500, 64'h8000_0504, 64'h8000_0600, 64'h8000_0700,
                             64'h8000_0704, 64'h8000_0010, 64'h8000_0800, 64'h8000_0800};
    logic [63:0] r1  [8] = '{64'd1, 64'd3, 64'd0, 64'd0, 64'd0, 64'd9, 64'd0, 64'd0};
    logic [63:0] r2  [8] = '{64'd2, 64'd3, 64'd0, 64'd0, 64'd0, 64'd9, 64'd0, 64'd0};
    for (int i = 0; i < 8; i++) begin
      if (i == 3)      // none with a stale taken prediction must redirect to pc+4
        resolve(fn[i], pcs[i], 64'h100, r1[i], r2[i], 1'b0, 1'b1, 64'h8000_0900);
      else
        resolve(fn[i], pcs[i], 64'hffff_ffff_ffff_ff00, r1[i], r2[i], 1'b1, 1'b0, 64'd0);
    end
    idle();
    check_lookup(64'h8000_0700);
    check_lookup(64'h8000_0800);
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_valid = 1'b1; i_brfunc = 4'b0100; i_pc = 64'h8000_0a00; i_imm = 64'h20;
    i_rs1data = 64'd1; i_rs2data = 64'd1; i_pred_taken = 1'b0; i_pred_target = 64'd0;
    #2;
    i_rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_redirect !== 1'b0 || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_redirect cyc=%0d got redir=%b v=%b exp 0", c, o_redirect, o_valid);
      end
      i_valid = 1'b0;
    end
    checks++;
    if (o_br_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_counters got br=%0d mis=%0d exp 0", o_br_cnt, o_mispred_cnt);
    end
    model_reset();
    check_lookup(64'h8000_0010);
    check_lookup(64'h8000_0800);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    resolve(4'b0001, 64'h8000_0010, 64'h40, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    idle();
    check_lookup(64'h8000_0010);
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_signed_unsigned();
    test_jalr();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
